// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM address, one-entry valid/ready output buffer.
// Branches redirect and flush; a HALT opcode parks the FSM until the next branch.
module fetch_unit #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_out_pc;

  logic w_fire;
  logic w_is_halt;
  logic w_drain;

  assign w_fire    = (r_state == S_RUN) && (!r_valid || out_ready);
  assign w_is_halt = (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign w_drain   = r_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      branch_valid:          w_state_nxt = S_RUN;
      w_fire && w_is_halt:   w_state_nxt = S_HALTED;
      default:               w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    halted    = (r_state == S_HALTED);
    imem_addr = r_pc;
    out_valid = r_valid;
    out_instr = r_instr;
    out_pc    = r_out_pc;
  end

  // Branch wins over capture; the flushed slot gives the one-cycle bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
    end else if (branch_valid) begin
      r_pc    <= branch_target;
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_instr  <= imem_data;
      r_out_pc <= r_pc;
      r_valid  <= 1'b1;
      r_pc     <= r_pc + 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational ROM model.
// Checks handshake, stall, branch flush, HALT, PC wrap and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;

  logic [15:0] rom [256];

  int n_cmp;
  int n_err;

  assign imem_data = rom[imem_addr];

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    out_ready     = rdy;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0298;
    rom[0] = 16'h0298;
    rom[1] = 16'h1298;
    rom[2] = 16'h2205;
    rom[3] = 16'h3280;
    rom[4] = 16'hF000;
  endtask

  logic [15:0] exp_i [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    fill_rom();
    exp_i[0] = 16'h0298;
    exp_i[1] = 16'h1298;
    exp_i[2] = 16'h2205;
    exp_i[3] = 16'h3280;

    // 1) reset state, then streaming at full rate
    rst_n = 1'b0;
    branch_valid = 1'b0;
    branch_target = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", {16'd0, out_instr}, 32'd0);
    check("rst_pc", {24'd0, out_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_pc", {24'd0, out_pc}, k);
      check("t1_instr", {16'd0, out_instr}, {16'd0, exp_i[k]});
    end

    // 2) stall for 3 cycles after first capture
    do_reset(1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_pc", {24'd0, out_pc}, 32'd0);
      check("t2_hold_instr", {16'd0, out_instr}, 32'h0298);
      check("t2_hold_addr", {24'd0, imem_addr}, 32'd1);
      check("t2_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t2_next_pc", {24'd0, out_pc}, 32'd1);
    check("t2_next_instr", {16'd0, out_instr}, 32'h1298);
    tick();
    check("t2_next2_pc", {24'd0, out_pc}, 32'd2);

    // 3) branch flushes a stalled word
    do_reset(1'b0);
    tick();
    check("t3_pre_valid", {31'd0, out_valid}, 32'd1);
    branch_valid = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    check("t3_bubble", {31'd0, out_valid}, 32'd0);
    check("t3_addr", {24'd0, imem_addr}, 32'h40);
    tick();
    check("t3_valid", {31'd0, out_valid}, 32'd1);
    check("t3_pc", {24'd0, out_pc}, 32'h40);

    // 4) HALT at address 4
    do_reset(1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("t4_pc", {24'd0, out_pc}, 32'd4);
    check("t4_instr", {16'd0, out_instr}, 32'hF000);
    check("t4_valid", {31'd0, out_valid}, 32'd1);
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_addr", {24'd0, imem_addr}, 32'd5);
    tick();
    check("t4_drain", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_park_valid", {31'd0, out_valid}, 32'd0);
    check("t4_park_addr", {24'd0, imem_addr}, 32'd5);
    check("t4_park_halted", {31'd0, halted}, 32'd1);
    branch_valid = 1'b1;
    branch_target = 8'h00;
    tick();
    branch_valid = 1'b0;
    check("t4_unhalt", {31'd0, halted}, 32'd0);
    check("t4_br_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_re_pc", {24'd0, out_pc}, 32'd0);
    check("t4_re_valid", {31'd0, out_valid}, 32'd1);

    // 5) PC wrap from FF
    for (int i = 0; i < 256; i++) rom[i] = 16'h0298;
    do_reset(1'b1);
    branch_valid = 1'b1;
    branch_target = 8'hFF;
    tick();
    branch_valid = 1'b0;
    tick();
    check("t5_pc_ff", {24'd0, out_pc}, 32'hFF);
    tick();
    check("t5_pc_00", {24'd0, out_pc}, 32'h00);
    tick();
    check("t5_pc_01", {24'd0, out_pc}, 32'h01);
    check("t5_valid", {31'd0, out_valid}, 32'd1);

    // 6) async reset mid-stream
    fill_rom();
    do_reset(1'b1);
    tick();
    tick();
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_addr", {24'd0, imem_addr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_first_pc", {24'd0, out_pc}, 32'd0);
    check("t6_first_instr", {16'd0, out_instr}, 32'h0298);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
